// File: rtl/jtframe_mcu_xbus_arb.sv
// Shares one single-port RAM between the 8751 xdata bus and the main CPU; JTFRAME_MCU_XBUS_FAIR_EN selects round-robin, else MCU priority.
// Latency: 3 clk from request to mcu_done/cpu_ok (IDLE->ACC->DATA); out-of-window MCU reads return 8'hFF at once.
// Backpressure: the MCU is stalled through mcu_cen while its access is pending; the CPU holds cpu_req until the cpu_ok pulse.
module jtframe_mcu_xbus_arb #(
   parameter int AW  = 11,
   parameter int WIN = 0
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   output logic          mcu_cen,
   input  logic [15:0]   mcu_addr,
   input  logic [7:0]    mcu_dout,
   input  logic          mcu_wr,
   input  logic          mcu_acc,
   output logic [7:0]    mcu_din,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_dout,
   input  logic          cpu_we,
   input  logic          cpu_req,
   output logic [7:0]    cpu_din,
   output logic          cpu_ok,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_din,
   output logic          ram_we,
   input  logic [7:0]    ram_q
);

   localparam logic [15-AW:0] WIN_SEL = (16-AW)'(WIN);

   typedef enum logic [1:0] {IDLE, ACC, DATA} state_t;

   state_t        state_q, state_d;
   logic          gnt_mcu_q, gnt_mcu_d;
   logic          wr_q, wr_d;
   logic          last_mcu_q, last_mcu_d;
   logic          mcu_done_q, mcu_done_d;
   logic          cpu_ok_q, cpu_ok_d;
   logic          ram_we_q, ram_we_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]    ram_din_q, ram_din_d;
   logic [7:0]    mcu_din_q, mcu_din_d;
   logic [7:0]    cpu_din_q, cpu_din_d;

   logic win_hit, mcu_req, mcu_pend, cpu_pend, pick_mcu;

   assign win_hit  = mcu_addr[15:AW] == WIN_SEL;
   assign mcu_req  = mcu_acc & win_hit;
   assign mcu_pend = mcu_req & ~mcu_done_q;
   assign mcu_cen  = cen & ~mcu_pend;
   // cpu_ok still high means cpu_req may be the stale level of the access just served
   assign cpu_pend = cpu_req & ~cpu_ok_q;

`ifdef JTFRAME_MCU_XBUS_FAIR_EN
   assign pick_mcu = mcu_pend & (~cpu_pend | ~last_mcu_q);
`else
   assign pick_mcu = mcu_pend;
`endif

   assign mcu_din  = win_hit ? mcu_din_q : 8'hFF;
   assign cpu_din  = cpu_din_q;
   assign cpu_ok   = cpu_ok_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign ram_we   = ram_we_q;

   always_comb begin
      state_d    = state_q;
      gnt_mcu_d  = gnt_mcu_q;
      wr_d       = wr_q;
      last_mcu_d = last_mcu_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      ram_we_d   = 1'b0;
      cpu_ok_d   = 1'b0;
      mcu_din_d  = mcu_din_q;
      cpu_din_d  = cpu_din_q;
      // mcu_done drops on the first enabled MCU cycle, when the core consumes the data
      mcu_done_d = mcu_done_q & ~mcu_cen;
      case (state_q)
         IDLE: begin
            if (mcu_pend || cpu_pend) begin
               state_d    = ACC;
               gnt_mcu_d  = pick_mcu;
               last_mcu_d = pick_mcu;
               if (pick_mcu) begin
                  ram_addr_d = mcu_addr[AW-1:0];
                  ram_din_d  = mcu_dout;
                  wr_d       = mcu_wr;
                  ram_we_d   = mcu_wr;
               end else begin
                  ram_addr_d = cpu_addr;
                  ram_din_d  = cpu_dout;
                  wr_d       = cpu_we;
                  ram_we_d   = cpu_we;
               end
            end
         end
         ACC: state_d = DATA;
         DATA: begin
            state_d = IDLE;
            if (gnt_mcu_q) begin
               mcu_done_d = 1'b1;
               if (!wr_q) mcu_din_d = ram_q;
            end else begin
               cpu_ok_d = 1'b1;
               if (!wr_q) cpu_din_d = ram_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_mcu_q  <= 1'b0;
         wr_q       <= 1'b0;
         last_mcu_q <= 1'b0;
         mcu_done_q <= 1'b0;
         cpu_ok_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= 8'h00;
         mcu_din_q  <= 8'hFF;
         cpu_din_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         gnt_mcu_q  <= gnt_mcu_d;
         wr_q       <= wr_d;
         last_mcu_q <= last_mcu_d;
         mcu_done_q <= mcu_done_d;
         cpu_ok_q   <= cpu_ok_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         mcu_din_q  <= mcu_din_d;
         cpu_din_q  <= cpu_din_d;
      end
   end

endmodule

// File: doc/jtframe_mcu_xbus_arb.md
JTFRAME_MCU_XBUS_ARB -- requirements
Module: jtframe_mcu_xbus_arb

Interface
REQ-001 SHALL have parameter AW, default 11: shared RAM address width (2 KB).
REQ-002 SHALL have parameter WIN, default 0: value of mcu_addr[15:AW] that selects the shared RAM window.
REQ-003 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port cen  input  1: MCU clock enable from the board clock divider.
REQ-006 SHALL have port mcu_cen  output  1: gated clock enable driven to the 8751 core.
REQ-007 SHALL have ports mcu_addr input 16, mcu_dout input 8, mcu_wr input 1, mcu_acc input 1: MCU external (xdata) bus.
REQ-008 SHALL have port mcu_din  output  8: read data returned to the MCU xdata input.
REQ-009 SHALL have ports cpu_addr input AW, cpu_dout input 8, cpu_we input 1, cpu_req input 1: main CPU request, level-held.
REQ-010 SHALL have ports cpu_din output 8, cpu_ok output 1: CPU read data and one-cycle completion pulse.
REQ-011 SHALL have ports ram_addr output AW, ram_din output 8, ram_we output 1, ram_q input 8: single-port RAM, ram_q valid one clk after ram_addr.

Function
REQ-012 SHALL treat an MCU request as mcu_acc=1 with mcu_addr[15:AW]==WIN.
REQ-013 SHALL return 8'hFF on mcu_din and never stall for MCU accesses outside the window.
REQ-014 SHALL drive mcu_cen = cen AND NOT mcu_pend, mcu_pend = MCU request present and not yet served (mcu_done=0).
REQ-015 SHALL implement states IDLE, ACC, DATA; IDLE->ACC on grant, ACC->DATA unconditionally, DATA->IDLE unconditionally.
REQ-016 SHALL in ACC drive ram_addr/ram_din from the granted requester and assert ram_we for exactly one cycle if a write.
REQ-017 SHALL in DATA capture ram_q into mcu_din (MCU grant) or cpu_din (CPU grant); for writes the data register holds its previous value.
REQ-018 SHALL in DATA set mcu_done=1 (MCU grant) or pulse cpu_ok for one cycle (CPU grant).
REQ-019 SHALL clear mcu_done on the first cycle where mcu_cen=1 after it was set.
REQ-020 SHALL give an uncontended access a latency of 3 clk from request to mcu_done/cpu_ok.
REQ-021 SHALL not re-grant the CPU in the cycle after cpu_ok, so a held cpu_req is not served twice; the CPU deasserts or changes cpu_req within one clk of cpu_ok.
REQ-022 SHALL latch address, data and direction at grant; requester changes during ACC/DATA do not affect the access.
REQ-023 SHALL, when only one requester is pending in IDLE, grant it.

Reset
REQ-024 SHALL on rst_n=0 asynchronously force state=IDLE, ram_we=0, cpu_ok=0, mcu_done=0, mcu_din=8'hFF, cpu_din=0, ram_addr=0, ram_din=0, last-grant=CPU.
REQ-025 SHALL abort any access in progress on reset; no ram_we pulse and no cpu_ok follow reset release.

Configuration
REQ-026 SHALL, with JTFRAME_MCU_XBUS_FAIR_EN defined, resolve simultaneous requests in IDLE round-robin: grant the requester not granted last.
REQ-027 SHALL, without JTFRAME_MCU_XBUS_FAIR_EN, always grant the MCU on simultaneous requests (fixed priority).

Verification
REQ-028 SHALL cover MCU write 0x5A to 0x0123, then MCU read 0x0123 -> one ram_we pulse at 0x123, mcu_din=0x5A, mcu_cen low exactly until mcu_done.
REQ-029 SHALL cover CPU read of 0x07FF preloaded 0xC3 -> cpu_ok one cycle, 3 clk after cpu_req, cpu_din=0xC3.
REQ-030 SHALL cover simultaneous MCU and CPU requests, last grant MCU, FAIR_EN defined -> CPU served first; undefined -> MCU served first, CPU cpu_ok 3 clk later.
REQ-031 SHALL cover MCU access to 0x8000 (outside window) -> mcu_din=0xFF, no stall, no RAM activity.
REQ-032 SHALL cover rst_n pulsed low during ACC of a CPU write -> no ram_we, no cpu_ok, all outputs at reset values.
REQ-033 SHALL cover cpu_req held 10 clk with cpu_addr fixed -> exactly one cpu_ok per completed grant, none on the cycle after cpu_ok.
